// File: rtl/mul_sched_pkg.sv
// Shared definitions for the shared-multiplier scheduler: FSM state encoding,
// default operand width and an index-width helper.
package mul_sched_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDA  = 3'd1,
    ST_LDB  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_sched_if.sv
// Requester, result and datapath-control bundle of the multiply scheduler.
// master = scheduler side, slave = requesters plus shift/add datapath.
interface mul_share_sched_if #(
  parameter int NREQ = 2,
  parameter int W    = mul_sched_pkg::W_DEFAULT
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [2*W-1:0]    res;
  logic              busy;
  logic [W-1:0]      dp_a;
  logic [W-1:0]      dp_b;
  logic              LdA;
  logic              LdB;
  logic              LdP;
  logic              clrP;
  logic              decB;
  logic              eqz;
  logic [2*W-1:0]    dp_p;

  modport master (
    input  req, a_in, b_in, eqz, dp_p,
    output gnt, res, busy, dp_a, dp_b, LdA, LdB, LdP, clrP, decB
  );

  modport slave (
    output req, a_in, b_in, eqz, dp_p,
    input  gnt, res, busy, dp_a, dp_b, LdA, LdB, LdP, clrP, decB
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot pick of the first request at or after the
// priority pointer; pointer moves past the served index on adv_i.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  input  logic [IW-1:0]   adv_idx_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found_s;
  int            pos_s;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (adv_idx_i == IW'(NREQ - 1)) ? '0 : adv_idx_i + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Scan requesters starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    pos_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos_s = (int'(ptr_q) + i >= NREQ) ? int'(ptr_q) + i - NREQ : int'(ptr_q) + i;
      if (!found_s && req_i[pos_s]) begin
        gnt_o[pos_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Schedules NREQ requesters onto one shift/add multiplier datapath.
// Optional MUL_SHARE_SCHED_SWAP_EN: smaller operand becomes the loop count.
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_share_sched_if.master bus
);

  localparam int IW = idx_width(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, win_idx_s;
  logic [NREQ-1:0] win_s, gnt_q, gnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, rem_q, rem_d, a_sel_s, b_sel_s;
  logic [W-1:0]    dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic [2*W-1:0]  res_q, res_d;
  logic            lda_q, lda_d, ldb_q, ldb_d, ldp_q, ldp_d, busy_q, busy_d;
  logic            adv_s;

  assign adv_s = (state_q == ST_DONE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req),
    .adv_i     (adv_s),
    .adv_idx_i (idx_q),
    .gnt_o     (win_s)
  );

  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_idx_s = win_s[i] ? IW'(i) : win_idx_s;
    end
  end

  assign a_sel_s = bus.a_in[win_idx_s*W +: W];
  assign b_sel_s = bus.b_in[win_idx_s*W +: W];

  // rem_q shadows the datapath B count so LdP/decB can come straight from flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_LDA;
          idx_d   = win_idx_s;
`ifdef MUL_SHARE_SCHED_SWAP_EN
          if (b_sel_s > a_sel_s) begin
            a_d = b_sel_s;
            b_d = a_sel_s;
          end else begin
            a_d = a_sel_s;
            b_d = b_sel_s;
          end
`else
          a_d = a_sel_s;
          b_d = b_sel_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LDA:  state_d = ST_LDB;
      ST_LDB: begin
        state_d = ST_ACC;
        rem_d   = b_q;
      end
      ST_ACC: begin
        state_d = bus.eqz ? ST_DONE : ST_ACC;
        rem_d   = ldp_q ? rem_q - W'(1) : rem_q;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    lda_d  = (state_d == ST_LDA);
    ldb_d  = (state_d == ST_LDB);
    ldp_d  = (state_d == ST_ACC) && (rem_d != '0);
    busy_d = (state_d != ST_IDLE);
    dp_a_d = lda_d ? a_d : '0;
    dp_b_d = ldb_d ? b_d : '0;
    res_d  = (state_d == ST_DONE) ? bus.dp_p : '0;
    gnt_d  = (state_d == ST_DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      lda_q   <= 1'b0;
      ldb_q   <= 1'b0;
      ldp_q   <= 1'b0;
      busy_q  <= 1'b0;
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      res_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      lda_q   <= lda_d;
      ldb_q   <= ldb_d;
      ldp_q   <= ldp_d;
      busy_q  <= busy_d;
      dp_a_q  <= dp_a_d;
      dp_b_q  <= dp_b_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.LdA  = lda_q;
  assign bus.LdB  = ldb_q;
  assign bus.clrP = ldb_q;
  assign bus.LdP  = ldp_q;
  assign bus.decB = ldp_q;
  assign bus.busy = busy_q;
  assign bus.dp_a = dp_a_q;
  assign bus.dp_b = dp_b_q;
  assign bus.res  = res_q;
  assign bus.gnt  = gnt_q;

endmodule
